lsq: RTL and testbench



---
 rtl/lsq.sv | 264 ++++++++++++++++++++++++++
 tb/tb_lsq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsq.sv
// Load/store queue: program-order buffer of memory ops with CDB operand snooping, single outstanding access.
// Optional LSQ_MMIO_EN: head loads at/above MMIO_BASE wait until they are the ROB head.
module lsq #(
    parameter int          DEPTH     = 8,
    parameter int          ROB_W     = 4,
    parameter int          CDB_N     = 2,
    parameter logic [31:0] MMIO_BASE = 32'h0003_0000
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   clear,
    output logic                   full,
    input  logic                   dec_valid,
    input  logic [3:0]             dec_type,
    input  logic [31:0]            dec_vj,
    input  logic [31:0]            dec_vk,
    input  logic                   dec_dj,
    input  logic                   dec_dk,
    input  logic [ROB_W-1:0]       dec_qj,
    input  logic [ROB_W-1:0]       dec_qk,
    input  logic [31:0]            dec_imm,
    input  logic [ROB_W-1:0]       dec_rob_id,
    input  logic [CDB_N-1:0]       cdb_valid,
    input  logic [CDB_N*ROB_W-1:0] cdb_rob_id,
    input  logic [CDB_N*32-1:0]    cdb_value,
    input  logic                   rob_commit,
    input  logic [ROB_W-1:0]       rob_commit_id,
    input  logic [ROB_W-1:0]       rob_head_id,
    output logic                   mem_req,
    output logic [31:0]            mem_addr,
    output logic [31:0]            mem_wdata,
    output logic [3:0]             mem_type,
    input  logic                   mem_done,
    input  logic [31:0]            mem_rdata,
    output logic                   out_valid,
    output logic [ROB_W-1:0]       out_rob_id,
    output logic [31:0]            out_value
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, REQ} state_t;
    state_t state_q, state_d;

    logic [3:0]       type_q   [DEPTH];
    logic [3:0]       type_d   [DEPTH];
    logic [31:0]      vj_q     [DEPTH];
    logic [31:0]      vj_d     [DEPTH];
    logic [31:0]      vk_q     [DEPTH];
    logic [31:0]      vk_d     [DEPTH];
    logic [ROB_W-1:0] qj_q     [DEPTH];
    logic [ROB_W-1:0] qj_d     [DEPTH];
    logic [ROB_W-1:0] qk_q     [DEPTH];
    logic [ROB_W-1:0] qk_d     [DEPTH];
    logic [31:0]      imm_q    [DEPTH];
    logic [31:0]      imm_d    [DEPTH];
    logic [ROB_W-1:0] rob_id_q [DEPTH];
    logic [ROB_W-1:0] rob_id_d [DEPTH];
    logic [DEPTH-1:0] dj_q, dj_d, dk_q, dk_d, committed_q, committed_d;

    logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [AW:0]      count_q, count_d, ncommit_q, ncommit_d;

    logic             mem_req_unused;
    logic [31:0]      mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [3:0]       mem_type_q, mem_type_d;
    logic             out_valid_q, out_valid_d;
    logic [ROB_W-1:0] out_rob_id_q, out_rob_id_d;
    logic [31:0]      out_value_q, out_value_d;

    logic [DEPTH-1:0] live;
    logic [AW-1:0]    off;
    logic [31:0]      head_addr, cap_vj, cap_vk;
    logic             head_is_store, head_ok, head_is_io, head_elig;
    logic             cap_dj, cap_dk;
    logic             issue, abandon, done, pop, bcast, enq;

    assign full = (count_q == (AW+1)'(DEPTH));

    // An entry is live when its distance from head is below count.
    always_comb begin
        live = '0;
        off  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off     = AW'(i) - head_q;
            live[i] = ({1'b0, off} < count_q);
        end
    end

    assign head_addr     = vj_q[head_q] + imm_q[head_q];
    assign head_is_store = type_q[head_q][3];
    assign head_is_io    = (head_addr >= MMIO_BASE);
    assign head_ok       = (count_q != '0) && !dj_q[head_q] &&
                           (!head_is_store || (!dk_q[head_q] && committed_q[head_q]));

`ifdef LSQ_MMIO_EN
    assign head_elig = head_ok &&
                       (head_is_store || !head_is_io || (rob_head_id == rob_id_q[head_q]));
`else
    logic unused_mmio;
    assign head_elig   = head_ok;
    assign unused_mmio = head_is_io ^ (^rob_head_id);
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)      state_q <= IDLE;
        else if (rdy_in) state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (issue) state_d = REQ;
            REQ:  if (abandon || done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A store in REQ is always committed, so only loads are abandoned on flush.
    always_comb begin
        issue   = (state_q == IDLE) && head_elig && !clear;
        abandon = (state_q == REQ) && clear && !head_is_store;
        done    = (state_q == REQ) && mem_done && !abandon;
        pop     = done;
        bcast   = done && !head_is_store && !clear;
    end

    assign mem_req        = (state_q == REQ);
    assign mem_req_unused = 1'b0;

    // Operand capture at enqueue; lowest bus index has the final word.
    always_comb begin
        cap_vj = dec_vj;
        cap_dj = dec_dj;
        cap_vk = dec_vk;
        cap_dk = dec_dk;
        for (int b = CDB_N-1; b >= 0; b--) begin
            if (dec_dj && cdb_valid[b] && cdb_rob_id[b*ROB_W +: ROB_W] == dec_qj) begin
                cap_vj = cdb_value[b*32 +: 32];
                cap_dj = 1'b0;
            end
            if (dec_dk && cdb_valid[b] && cdb_rob_id[b*ROB_W +: ROB_W] == dec_qk) begin
                cap_vk = cdb_value[b*32 +: 32];
                cap_dk = 1'b0;
            end
        end
    end

    always_comb begin
        type_d      = type_q;
        vj_d        = vj_q;
        vk_d        = vk_q;
        qj_d        = qj_q;
        qk_d        = qk_q;
        imm_d       = imm_q;
        rob_id_d    = rob_id_q;
        dj_d        = dj_q;
        dk_d        = dk_q;
        committed_d = committed_q;

        enq       = dec_valid && !full && !clear;
        ncommit_d = ncommit_q + (AW+1)'(rob_commit) - (AW+1)'(pop && head_is_store);
        head_d    = head_q + AW'(pop);
        if (clear) begin
            tail_d  = head_d + ncommit_d[AW-1:0];
            count_d = ncommit_d;
        end else begin
            tail_d  = tail_q + AW'(enq);
            count_d = count_q + (AW+1)'(enq) - (AW+1)'(pop);
        end

        for (int i = 0; i < DEPTH; i++) begin
            for (int b = CDB_N-1; b >= 0; b--) begin
                if (live[i] && cdb_valid[b] && cdb_rob_id[b*ROB_W +: ROB_W] == qj_q[i] && dj_q[i]) begin
                    vj_d[i] = cdb_value[b*32 +: 32];
                    dj_d[i] = 1'b0;
                end
                if (live[i] && cdb_valid[b] && cdb_rob_id[b*ROB_W +: ROB_W] == qk_q[i] && dk_q[i]) begin
                    vk_d[i] = cdb_value[b*32 +: 32];
                    dk_d[i] = 1'b0;
                end
            end
            if (live[i] && rob_commit && rob_id_q[i] == rob_commit_id)
                committed_d[i] = 1'b1;
        end

        if (enq) begin
            type_d[tail_q]      = dec_type;
            vj_d[tail_q]        = cap_vj;
            vk_d[tail_q]        = cap_vk;
            dj_d[tail_q]        = cap_dj;
            dk_d[tail_q]        = cap_dk;
            qj_d[tail_q]        = dec_qj;
            qk_d[tail_q]        = dec_qk;
            imm_d[tail_q]       = dec_imm;
            rob_id_d[tail_q]    = dec_rob_id;
            committed_d[tail_q] = 1'b0;
        end

        mem_addr_d   = issue ? head_addr      : mem_addr_q;
        mem_wdata_d  = issue ? vk_q[head_q]   : mem_wdata_q;
        mem_type_d   = issue ? type_q[head_q] : mem_type_q;
        out_valid_d  = bcast;
        out_rob_id_d = bcast ? rob_id_q[head_q] : out_rob_id_q;
        out_value_d  = bcast ? mem_rdata        : out_value_q;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                type_q[i]   <= '0;
                vj_q[i]     <= '0;
                vk_q[i]     <= '0;
                qj_q[i]     <= '0;
                qk_q[i]     <= '0;
                imm_q[i]    <= '0;
                rob_id_q[i] <= '0;
            end
            dj_q         <= '0;
            dk_q         <= '0;
            committed_q  <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            ncommit_q    <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_type_q   <= '0;
            out_valid_q  <= 1'b0;
            out_rob_id_q <= '0;
            out_value_q  <= '0;
        end else if (rdy_in) begin
            type_q       <= type_d;
            vj_q         <= vj_d;
            vk_q         <= vk_d;
            qj_q         <= qj_d;
            qk_q         <= qk_d;
            imm_q        <= imm_d;
            rob_id_q     <= rob_id_d;
            dj_q         <= dj_d;
            dk_q         <= dk_d;
            committed_q  <= committed_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            ncommit_q    <= ncommit_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_type_q   <= mem_type_d;
            out_valid_q  <= out_valid_d;
            out_rob_id_q <= out_rob_id_d;
            out_value_q  <= out_value_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_type   = mem_type_q;
    assign out_valid  = out_valid_q;
    assign out_rob_id = out_rob_id_q;
    assign out_value  = out_value_q;

endmodule

// File: tb/tb_lsq.sv
// Directed bench for lsq (DEPTH=4): load vector table plus hand sequences for
// snoop, stall, store commit, flush, full/wrap and MMIO gating.
module tb_lsq;
    localparam int DEPTH = 4;
    localparam int ROB_W = 4;
    localparam int CDB_N = 2;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear, full;
    logic        dec_valid, dec_dj, dec_dk;
    logic [3:0]  dec_type, dec_qj, dec_qk, dec_rob_id;
    logic [31:0] dec_vj, dec_vk, dec_imm;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_rob_id;
    logic [63:0] cdb_value;
    logic        rob_commit;
    logic [3:0]  rob_commit_id, rob_head_id;
    logic        mem_req, mem_done, out_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, out_value;
    logic [3:0]  mem_type, out_rob_id;

    int n_tests = 0;
    int n_fail  = 0;

    lsq #(.DEPTH(DEPTH), .ROB_W(ROB_W), .CDB_N(CDB_N), .MMIO_BASE(32'h0003_0000)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear), .full(full),
        .dec_valid(dec_valid), .dec_type(dec_type), .dec_vj(dec_vj), .dec_vk(dec_vk),
        .dec_dj(dec_dj), .dec_dk(dec_dk), .dec_qj(dec_qj), .dec_qk(dec_qk),
        .dec_imm(dec_imm), .dec_rob_id(dec_rob_id),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
        .rob_commit(rob_commit), .rob_commit_id(rob_commit_id), .rob_head_id(rob_head_id),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_type(mem_type),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_rob_id(out_rob_id), .out_value(out_value)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  typ;
        logic [31:0] vj;
        logic [31:0] imm;
        logic        dj;
        logic [3:0]  qj;
        logic [1:0]  cv;
        logic [7:0]  cid;
        logic [63:0] cval;
        logic [3:0]  rob;
        logic [31:0] rdata;
        logic [31:0] addr;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic enq(input logic [3:0] typ, input logic [31:0] vj, input logic [31:0] vk,
                       input logic [31:0] imm, input logic dj, input logic [3:0] qj,
                       input logic [3:0] rob);
        dec_valid = 1'b1; dec_type = typ; dec_vj = vj; dec_vk = vk; dec_imm = imm;
        dec_dj = dj; dec_qj = qj; dec_dk = 1'b0; dec_qk = '0; dec_rob_id = rob;
        tick();
        dec_valid = 1'b0;
    endtask

    // Waits (bounded) for the request, checks it, completes it and checks the broadcast.
    task automatic serve(input string nm, input logic [31:0] addr, input logic [3:0] rob,
                         input logic [31:0] rdata, input logic is_load);
        int n = 0;
        while (!mem_req && n < 20) begin
            tick();
            n++;
        end
        chk({nm, " req"}, mem_req, 1);
        chk({nm, " addr"}, mem_addr, addr);
        mem_done = 1'b1; mem_rdata = rdata;
        tick();
        mem_done = 1'b0;
        chk({nm, " out_valid"}, out_valid, is_load);
        if (is_load) begin
            chk({nm, " out_rob"}, out_rob_id, rob);
            chk({nm, " out_value"}, out_value, rdata);
        end
        chk({nm, " req low"}, mem_req, 0);
    endtask

    initial begin
        vecs[0] = '{4'h2, 32'h100, 32'h4, 1'b0, 4'd0, 2'b00, 8'h00, 64'h0, 4'd3, 32'hDEADBEEF, 32'h104};
        vecs[1] = '{4'h0, 32'h0, 32'h10, 1'b1, 4'd5, 2'b10, 8'h50, 64'h00000200_00000000, 4'd7, 32'hFFFFFF80, 32'h210};
        vecs[2] = '{4'h1, 32'h0, 32'h0, 1'b1, 4'd9, 2'b11, 8'h99, 64'h00002000_00001000, 4'd4, 32'h00001234, 32'h1000};
        vecs[3] = '{4'h2, 32'hFFFFFFFF, 32'h2, 1'b0, 4'd0, 2'b00, 8'h00, 64'h0, 4'd9, 32'h5A5A5A5A, 32'h1};
        vecs[4] = '{4'h4, 32'h30, 32'hFFFFFFF0, 1'b0, 4'd0, 2'b00, 8'h00, 64'h0, 4'd10, 32'h0000007F, 32'h20};
        vecs[5] = '{4'h5, 32'h0, 32'h6, 1'b1, 4'd3, 2'b11, 8'h32, 64'h00004000_00000999, 4'd11, 32'h0000BEEF, 32'h4006};

        rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0;
        dec_valid = 1'b0; dec_type = '0; dec_vj = '0; dec_vk = '0; dec_imm = '0;
        dec_dj = 1'b0; dec_dk = 1'b0; dec_qj = '0; dec_qk = '0; dec_rob_id = '0;
        cdb_valid = '0; cdb_rob_id = '0; cdb_value = '0;
        rob_commit = 1'b0; rob_commit_id = '0; rob_head_id = '0;
        mem_done = 1'b0; mem_rdata = '0;
        tick(); tick();
        rst_in = 1'b0;
        tick();

        chk("rst full", full, 0);
        chk("rst mem_req", mem_req, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        chk("rst mem_type", mem_type, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_rob", out_rob_id, 0);
        chk("rst out_value", out_value, 0);

        // Load vectors: exact one-cycle issue latency and one-cycle broadcast latency.
        for (int v = 0; v < 6; v++) begin
            dec_valid = 1'b1; dec_type = vecs[v].typ; dec_vj = vecs[v].vj; dec_vk = '0;
            dec_imm = vecs[v].imm; dec_dj = vecs[v].dj; dec_qj = vecs[v].qj;
            dec_dk = 1'b0; dec_qk = '0; dec_rob_id = vecs[v].rob;
            cdb_valid = vecs[v].cv; cdb_rob_id = vecs[v].cid; cdb_value = vecs[v].cval;
            tick();
            dec_valid = 1'b0; cdb_valid = '0;
            chk($sformatf("vec%0d req after enq", v), mem_req, 0);
            tick();
            chk($sformatf("vec%0d req", v), mem_req, 1);
            chk($sformatf("vec%0d addr", v), mem_addr, vecs[v].addr);
            chk($sformatf("vec%0d type", v), mem_type, vecs[v].typ);
            mem_done = 1'b1; mem_rdata = vecs[v].rdata;
            tick();
            mem_done = 1'b0;
            chk($sformatf("vec%0d out_valid", v), out_valid, 1);
            chk($sformatf("vec%0d out_rob", v), out_rob_id, vecs[v].rob);
            chk($sformatf("vec%0d out_value", v), out_value, vecs[v].rdata);
            chk($sformatf("vec%0d req low", v), mem_req, 0);
            tick();
            chk($sformatf("vec%0d pulse", v), out_valid, 0);
        end

        // Snoop wakeup of a queued load, then a stall while mem_done is high.
        enq(4'h2, 32'h0, 32'h0, 32'h8, 1'b1, 4'd6, 4'd13);
        tick();
        chk("snoop waiting", mem_req, 0);
        cdb_valid = 2'b01; cdb_rob_id = 8'h06; cdb_value = 64'h0000_0400;
        tick();
        cdb_valid = '0;
        chk("snoop eligible next", mem_req, 0);
        tick();
        chk("snoop req", mem_req, 1);
        chk("snoop addr", mem_addr, 32'h408);
        rdy_in = 1'b0; mem_done = 1'b1; mem_rdata = 32'h77;
        tick(); tick();
        chk("stall req held", mem_req, 1);
        chk("stall no out", out_valid, 0);
        rdy_in = 1'b1;
        tick();
        mem_done = 1'b0;
        chk("stall release out", out_valid, 1);
        chk("stall release value", out_value, 32'h77);
        tick();

        // Store waits for commit; no broadcast on completion.
        dec_dk = 1'b0;
        enq(4'hA, 32'h80, 32'hCAFEF00D, 32'h8, 1'b0, 4'd0, 4'd2);
        tick(); tick();
        chk("store uncommitted", mem_req, 0);
        rob_commit = 1'b1; rob_commit_id = 4'd2;
        tick();
        rob_commit = 1'b0;
        chk("store commit edge", mem_req, 0);
        tick();
        chk("store req", mem_req, 1);
        chk("store addr", mem_addr, 32'h88);
        chk("store wdata", mem_wdata, 32'hCAFEF00D);
        chk("store type", mem_type, 32'hA);
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        chk("store no out", out_valid, 0);
        chk("store req low", mem_req, 0);

        // Flush: committed store survives, younger loads are dropped.
        enq(4'hA, 32'h40, 32'h11, 32'h0, 1'b0, 4'd0, 4'd1);
        enq(4'h2, 32'h500, 32'h0, 32'h0, 1'b0, 4'd0, 4'd2);
        enq(4'h2, 32'h504, 32'h0, 32'h0, 1'b0, 4'd0, 4'd3);
        rob_commit = 1'b1; rob_commit_id = 4'd1;
        tick();
        rob_commit = 1'b0;
        tick();
        chk("flush store req", mem_req, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("flush store kept", mem_req, 1);
        chk("flush store addr", mem_addr, 32'h40);
        serve("flush store", 32'h40, 4'd1, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("flush drop req %0d", i), mem_req, 0);
            chk($sformatf("flush drop out %0d", i), out_valid, 0);
        end

        // Load in flight is abandoned by flush, even with mem_done in that cycle.
        enq(4'h2, 32'h900, 32'h0, 32'h0, 1'b0, 4'd0, 4'd5);
        tick();
        chk("abandon req", mem_req, 1);
        clear = 1'b1; mem_done = 1'b1; mem_rdata = 32'h1;
        tick();
        clear = 1'b0; mem_done = 1'b0;
        chk("abandon req low", mem_req, 0);
        chk("abandon no out", out_valid, 0);
        tick(); tick();
        chk("abandon gone", mem_req, 0);

        // Full, dropped enqueue, wrap and ordering.
        enq(4'h2, 32'h0, 32'h0, 32'h0, 1'b1, 4'd12, 4'd8);
        enq(4'h2, 32'h0, 32'h0, 32'h0, 1'b1, 4'd13, 4'd9);
        enq(4'h2, 32'h0, 32'h0, 32'h0, 1'b1, 4'd14, 4'd10);
        chk("three not full", full, 0);
        enq(4'h2, 32'h0, 32'h0, 32'h0, 1'b1, 4'd15, 4'd11);
        chk("four full", full, 1);
        enq(4'h2, 32'h999, 32'h0, 32'h0, 1'b0, 4'd0, 4'd13);
        chk("still full", full, 1);
        cdb_valid = 2'b01; cdb_rob_id = 8'h0C; cdb_value = 64'h0000_0600;
        tick();
        cdb_valid = '0;
        serve("wrap A", 32'h600, 4'd8, 32'hA0, 1'b1);
        chk("pop not full", full, 0);
        enq(4'h2, 32'h700, 32'h0, 32'h0, 1'b0, 4'd0, 4'd1);
        chk("refill full", full, 1);
        cdb_valid = 2'b11; cdb_rob_id = 8'hED; cdb_value = 64'h00000620_00000610;
        tick();
        cdb_valid = 2'b01; cdb_rob_id = 8'h0F; cdb_value = 64'h0000_0630;
        tick();
        cdb_valid = '0;
        serve("wrap B", 32'h610, 4'd9, 32'hB0, 1'b1);
        serve("wrap C", 32'h620, 4'd10, 32'hC0, 1'b1);
        serve("wrap D", 32'h630, 4'd11, 32'hD0, 1'b1);
        serve("wrap E", 32'h700, 4'd1, 32'hE0, 1'b1);
        tick();
        chk("wrap empty", mem_req, 0);

        // I/O load gating on ROB head.
        rob_head_id = 4'd4;
        enq(4'h2, 32'h30000, 32'h0, 32'h0, 1'b0, 4'd0, 4'd6);
        tick(); tick();
`ifdef LSQ_MMIO_EN
        chk("mmio held", mem_req, 0);
        rob_head_id = 4'd6;
`else
        chk("mmio ordinary", mem_req, 1);
`endif
        serve("mmio", 32'h30000, 4'd6, 32'h00C0FFEE, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
